// File: rtl/load_store_unit.sv
`default_nettype none
// ==== load_store_unit : word-aligned big-endian load/store sequencer (rev 1.0) ====
// Sub-word loads extract and extend a lane; sub-word stores read-modify-write.
module load_store_unit #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic [ADDR_LEN-1:0] mem_address,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [WORD_LEN-1:0] mem_write_bus,
  input  logic [WORD_LEN-1:0] mem_out_bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [1:0]          size_q;
  logic [1:0]          offset_q;
  logic                signed_q;
  logic [15:0]         wdata_lo;
  logic [WORD_LEN-1:0] wbuf;

  logic                req_err;
  logic [4:0]          lane_shift;
  logic [WORD_LEN-1:0] lanes_up;
  logic [WORD_LEN-1:0] load_value;
  logic [WORD_LEN-1:0] lane_mask;
  logic [WORD_LEN-1:0] lane_data;
  logic [WORD_LEN-1:0] merged;

  assign req_err = (req_size == SZ_ILL)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (|req_addr[1:0]));

  // Shifting the addressed lane up to the MSBs turns big-endian extraction into a fixed slice.
  assign lane_shift = {offset_q, 3'b000};
  assign lanes_up   = mem_out_bus << lane_shift;

  always_comb begin
    load_value = lanes_up;
    case (size_q)
      SZ_BYTE: load_value = {{24{signed_q & lanes_up[31]}}, lanes_up[31:24]};
      SZ_HALF: load_value = {{16{signed_q & lanes_up[31]}}, lanes_up[31:16]};
      default: load_value = lanes_up;
    endcase
  end

  assign lane_mask = ((size_q == SZ_BYTE) ? 32'hFF00_0000 : 32'hFFFF_0000) >> lane_shift;
  assign lane_data = ((size_q == SZ_BYTE) ? {wdata_lo[7:0], 24'h0} : {wdata_lo, 16'h0}) >> lane_shift;
  assign merged    = (mem_out_bus & ~lane_mask) | lane_data;

  assign mem_write_bus = wbuf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                  state_next = RESP;
          else if (!req_write)          state_next = LOAD;
          else if (req_size == SZ_WORD) state_next = WRITE;
          else                          state_next = MERGE;
        end
      end
      LOAD: begin
        mem_read_en = 1'b1;
        state_next  = RESP;
      end
      MERGE: begin
        mem_read_en = 1'b1;
        state_next  = WRITE;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        state_next   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q      <= 2'b00;
      offset_q    <= 2'b00;
      signed_q    <= 1'b0;
      wdata_lo    <= 16'h0;
      wbuf        <= '0;
      mem_address <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q      <= req_size;
            offset_q    <= req_addr[1:0];
            signed_q    <= req_signed;
            wdata_lo    <= req_wdata[15:0];
            mem_address <= {req_addr[ADDR_LEN-1:2], 2'b00};
            resp_err    <= req_err;
            resp_rdata  <= '0;
            if (req_write && (req_size == SZ_WORD)) wbuf <= req_wdata;
          end
        end
        LOAD:    resp_rdata <= load_value;
        MERGE:   wbuf <= merged;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ==== tb_load_store_unit : randomized + directed bench against a byte-array reference model (rev 1.0) ====
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_address, mem_write_bus, mem_out_bus;
  logic        mem_read_en, mem_write_en;

  load_store_unit #(.WORD_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_bus(mem_write_bus), .mem_out_bus(mem_out_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory (what the DUT talks to) and the model's expected memory.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  assign mem_out_bus = mem[mem_address[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h1122_8344;
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_address[9:2]] <= mem_write_bus;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected outcome of the transaction in flight.
  bit          busy = 1'b0;
  int          acc = 0, prev_acc = 0, d, e_lat, last_d;
  logic        e_err, e_write, last_err;
  logic [1:0]  e_size;
  logic [7:0]  e_idx;
  logic [31:0] e_rdata, e_word, e_aligned, last_rdata;
  logic [7:0]  mb [4];
  int          mo;

  initial begin
    @(negedge clk);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    forever begin
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          d = cyc - acc;
          check("resp_valid", resp_valid, d == e_lat);
          check("req_ready busy", req_ready, 0);
          check("mem_read_en", mem_read_en, !e_err && d == 1 && !(e_write && e_size == 2'b10));
          check("mem_write_en", mem_write_en, !e_err && e_write && d == e_lat - 1);
          if (mem_read_en || mem_write_en) check("mem_address", mem_address, e_aligned);
          if (mem_write_en) check("mem_write_bus", mem_write_bus, e_word);
          if (d == e_lat) begin
            check("resp_err", resp_err, e_err);
            check("resp_rdata", resp_rdata, e_rdata);
            if (e_write && !e_err) ref_mem[e_idx] = e_word;
            check("mem word", mem[e_idx], ref_mem[e_idx]);
            last_rdata = resp_rdata;
            last_err   = resp_err;
            last_d     = d;
            busy       = 1'b0;
          end
        end else begin
          check("req_ready idle", req_ready, 1);
          check("resp_valid idle", resp_valid, 0);
          check("mem_read_en idle", mem_read_en, 0);
          check("mem_write_en idle", mem_write_en, 0);
        end
        if (!busy && req_valid && req_ready) begin
          mo        = int'(req_addr[1:0]);
          e_err     = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && mo != 0);
          e_write   = req_write;
          e_size    = req_size;
          e_idx     = req_addr[9:2];
          e_aligned = req_addr & ~32'h3;
          e_lat     = e_err ? 1 : ((req_write && req_size != 2'b10) ? 3 : 2);
          for (int i = 0; i < 4; i++) mb[i] = 8'(ref_mem[e_idx] >> (24 - 8 * i));
          e_rdata = 32'h0;
          e_word  = ref_mem[e_idx];
          if (!e_err && !req_write) begin
            case (req_size)
              2'b00:   e_rdata = {{24{req_signed & mb[mo][7]}}, mb[mo]};
              2'b01:   e_rdata = {{16{req_signed & mb[mo][7]}}, mb[mo], mb[mo+1]};
              default: e_rdata = ref_mem[e_idx];
            endcase
          end else if (!e_err) begin
            if (req_size == 2'b10) begin
              e_word = req_wdata;
            end else begin
              if (req_size == 2'b00) mb[mo] = req_wdata[7:0];
              else begin
                mb[mo]   = req_wdata[15:8];
                mb[mo+1] = req_wdata[7:0];
              end
              e_word = {mb[0], mb[1], mb[2], mb[3]};
            end
          end
          prev_acc = acc;
          acc      = cyc;
          busy     = 1'b1;
        end
      end
      @(negedge clk);
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 12) begin @(posedge clk); #1; k++; end
    check("resp timeout", {31'b0, busy}, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    int k;
    k = 0;
    while (!req_ready && k < 40) begin @(posedge clk); #1; k++; end
    check("ready timeout", req_ready, 1);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"}, req_ready, 1);
    check({tag, " resp_valid"}, resp_valid, 0);
    check({tag, " resp_err"}, resp_err, 0);
    check({tag, " mem_read_en"}, mem_read_en, 0);
    check({tag, " mem_write_en"}, mem_write_en, 0);
    check({tag, " resp_rdata"}, resp_rdata, 0);
    check({tag, " mem_address"}, mem_address, 0);
    check({tag, " mem_write_bus"}, mem_write_bus, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word and sub-word loads from 0x100 = 11 22 83 44
    issue(0, 2'b10, 0, 32'h100, 0, 0);
    check("lw rdata", last_rdata, 32'h1122_8344);
    check("lw err", last_err, 0);
    check("lw latency", last_d, 2);
    issue(0, 2'b00, 1, 32'h102, 0, 0); check("lb rdata", last_rdata, 32'hFFFF_FF83);
    issue(0, 2'b00, 0, 32'h102, 0, 0); check("lbu rdata", last_rdata, 32'h0000_0083);
    issue(0, 2'b01, 1, 32'h102, 0, 0); check("lh rdata", last_rdata, 32'hFFFF_8344);
    issue(0, 2'b01, 0, 32'h100, 0, 0); check("lhu rdata", last_rdata, 32'h0000_1122);

    // Sub-word stores
    issue(1, 2'b00, 0, 32'h101, 32'h0000_00AB, 0);
    check("sb latency", last_d, 3);
    check("sb word", mem[8'h40], 32'h11AB_8344);
    issue(1, 2'b01, 0, 32'h102, 32'h0000_BEEF, 0);
    check("sh word", mem[8'h40], 32'h11AB_BEEF);
    issue(1, 2'b10, 0, 32'h100, 32'h1122_8344, 0);

    // Errors
    issue(0, 2'b01, 1, 32'h101, 0, 0);
    check("lh mis err", last_err, 1); check("lh mis rdata", last_rdata, 0); check("err latency", last_d, 1);
    issue(1, 2'b10, 0, 32'h102, 32'hCAFE_F00D, 0);
    check("sw mis err", last_err, 1); check("sw mis word", mem[8'h40], 32'h1122_8344);
    issue(0, 2'b11, 0, 32'h100, 0, 0);
    check("size11 err", last_err, 1);

    // Reset during MERGE of a byte store
    req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h100; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort ready", req_ready, 1);
    check("abort word", mem[8'h40], 32'h1122_8344);
    @(posedge clk); #1;

    // Back-to-back: valid held high through RESP
    req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h100; req_wdata = 0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1; req_addr = 32'h104; req_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle();
    check("b2b accept gap", acc - prev_acc, 3);
    check("b2b word", mem[8'h41], 32'hDEAD_BEEF);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 3) == 0);
    end
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sequencing front end that sits directly upstream of the byte-addressed, big-endian data memory. It accepts one load/store request at a time from the datapath and issues only word-aligned accesses to the memory. Sub-word loads are served by lane extraction plus sign or zero extension. Sub-word stores are served by a read-modify-write, because the memory writes only whole words.

## Interface
- `WORD_LEN`, 32, data word width; fixed at 32 in this block.
- `ADDR_LEN`, 32, byte-address width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted when `req_valid && req_ready` at the clock edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  encoding: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  ADDR_LEN  byte address.
- `req_wdata`  in  WORD_LEN  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualified by `resp_valid`; marks misaligned address or illegal size.
- `resp_rdata`  out  WORD_LEN  load result, qualified by `resp_valid`; 0 for stores and errors.
- `mem_address`  out  ADDR_LEN  word-aligned address (`addr & ~3`).
- `mem_read_en`  out  1  memory read enable.
- `mem_write_en`  out  1  memory write enable.
- `mem_write_bus`  out  WORD_LEN  word to write.
- `mem_out_bus`  in  WORD_LEN  memory read data; combinational from `mem_address`.

## Operation
- **Request latch:** on acceptance, the unit registers write, size, signed, addr and wdata. Inputs are ignored until the next acceptance.
- **Alignment:** halfword requires `addr[0]=0`; word requires `addr[1:0]=0`. Misaligned address or size 11 goes to error.
- **Byte lanes (big-endian):** offset `o = addr[1:0]`.
  - Byte = `word[31-8o -: 8]`.
  - Half = `word[31-8o -: 16]`.
  - Store merge replaces only those bits with `wdata[7:0]` or `wdata[15:0]`.
- **FSM states:** IDLE, LOAD, MERGE, WRITE, RESP.
  - **IDLE:** `req_ready=1`. On accept:
    - error → RESP with err = 1;
    - load → LOAD;
    - word store → WRITE, with wbuf = wdata;
    - byte/half store → MERGE.
  - **LOAD:** `mem_read_en=1`; capture the extracted and extended value into `resp_rdata`; → RESP.
  - **MERGE:** `mem_read_en=1`; capture `mem_out_bus` with the merged lanes into wbuf; → WRITE.
  - **WRITE:** `mem_write_en=1`, `mem_write_bus=wbuf`; the memory commits at the ending edge; → RESP.
  - **RESP:** `resp_valid=1`, `req_ready=0`; → IDLE.
- **Quiet outputs:** `mem_read_en` and `mem_write_en` are 0 in every state not listed above. `mem_address` holds the latched aligned address.
- **Errors:** an error request never asserts `mem_read_en` or `mem_write_en`.

## Timing
- Request accepted at the edge ending cycle n. `resp_valid` is high in:
  - cycle n+1 for an error;
  - cycle n+2 for a load or word store;
  - cycle n+3 for a byte/half store.
- **Throughput:** the next acceptance is no earlier than the cycle after RESP. A `req_valid` held high through RESP is accepted in the first IDLE cycle.
- **Write enable:** `mem_write_en` is high for exactly one cycle per successful store and never for loads.
- **Reset values:**
  - state = IDLE, so `req_ready=1`;
  - `resp_valid`, `resp_err`, `mem_read_en`, `mem_write_en` = 0;
  - `resp_rdata`, `mem_address`, `mem_write_bus`, wbuf = 0.
- **Reset mid-operation:** asynchronous return to IDLE with `mem_write_en` forced low immediately. A read-modify-write aborted in MERGE leaves memory unchanged. No `resp_valid` is issued for an aborted request.

## Test plan
Preload the word at 0x100 with bytes 11 22 83 44, i.e. 0x11228344.

1. **Word load:** lw 0x100 → `resp_rdata=0x11228344`, err = 0, `resp_valid` at n+2, no write pulse.
2. **Sub-word loads:**
   - lb 0x102 signed → 0xFFFFFF83;
   - lbu 0x102 → 0x00000083;
   - lh 0x102 signed → 0xFFFF8344;
   - lhu 0x100 → 0x00001122.
3. **Sub-word stores:**
   - sb 0x101, wdata 0x000000AB → word becomes 0x11AB8344; `resp_valid` at n+3; exactly one `mem_write_en` cycle with address 0x100;
   - then sh 0x102, wdata 0x0000BEEF → 0x11ABBEEF.
4. **Errors:**
   - lh 0x101 → err = 1 at n+1, rdata 0, no `mem_read_en` or `mem_write_en`;
   - sw 0x102 → err, memory unchanged;
   - size 11 → err.
5. **Reset mid-RMW:** sb 0x100 with `rst_n` pulsed low during MERGE → memory still 0x11228344, outputs at reset values, `req_ready=1` after release.
6. **Back-to-back:** `req_valid` held high with lw 0x100 then sw 0x104 0xDEADBEEF → second accept in the cycle after the first RESP; word 0x104 reads back 0xDEADBEEF.
